// File: rtl/page_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : page_ctrl
//  Description : Start/menu page sequencer. Converts four debounced buttons
//                into page select, option highlight, blink phase and fade
//                brightness for the page renderers, plus a start pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module page_ctrl #(
  parameter int NUM_OPTS     = 2,
  parameter int SEL_W        = 1,
  parameter int BLINK_FRAMES = 30,
  parameter int FADE_FRAMES  = 4
) (
  input  logic             clk_25MHz,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             btn_enter,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_back,
  output logic [1:0]       page,
  output logic [SEL_W-1:0] sel,
  output logic             opt,
  output logic [3:0]       fade_level,
  output logic             start_pulse
);

  // Page encoding doubles as the page output.
  localparam logic [1:0] ST_TITLE = 2'd0;
  localparam logic [1:0] ST_MENU  = 2'd1;
  localparam logic [1:0] ST_FADE  = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd3;

  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int FADE_W  = (FADE_FRAMES  > 1) ? $clog2(FADE_FRAMES)  : 1;

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);
  localparam logic [FADE_W-1:0]  FADE_LAST  = FADE_W'(FADE_FRAMES - 1);
  localparam logic [FADE_W-1:0]  FADE_ONE   = FADE_W'(1);
  localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NUM_OPTS - 1);
  localparam logic [SEL_W-1:0]   SEL_ONE    = SEL_W'(1);
  localparam logic [3:0]         FADE_FULL  = 4'd15;

  // Button bit order: {back, right, left, enter}
  logic [3:0] btn_raw;
  logic [3:0] btn_meta;
  logic [3:0] btn_sync;
  logic [3:0] btn_prev;
  logic [3:0] ev;

  logic ev_enter;
  logic ev_left;
  logic ev_right;
  logic ev_back;

  logic [1:0]         state;
  logic [1:0]         state_d;
  logic [SEL_W-1:0]   sel_d;
  logic [3:0]         fade_d;
  logic [FADE_W-1:0]  fade_cnt;
  logic [FADE_W-1:0]  fade_cnt_d;
  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_cnt_d;
  logic               opt_d;
  logic               start_d;

  assign btn_raw  = {btn_back, btn_right, btn_left, btn_enter};
  assign ev_enter = ev[0];
  assign ev_left  = ev[1];
  assign ev_right = ev[2];
  assign ev_back  = ev[3];

  // Two-flop synchronizer followed by a registered rising-edge detector;
  // each press yields a single one-cycle event three clocks after the pin.
  always_ff @(posedge clk_25MHz) begin
    if (!rst) begin
      btn_meta <= 4'd0;
      btn_sync <= 4'd0;
      btn_prev <= 4'd0;
      ev       <= 4'd0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
      ev       <= btn_sync & ~btn_prev;
    end
  end

  // State register: page, selection, counters and all outputs.
  always_ff @(posedge clk_25MHz) begin
    if (!rst) begin
      state       <= ST_TITLE;
      sel         <= '0;
      fade_level  <= FADE_FULL;
      fade_cnt    <= '0;
      blink_cnt   <= '0;
      opt         <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      state       <= state_d;
      sel         <= sel_d;
      fade_level  <= fade_d;
      fade_cnt    <= fade_cnt_d;
      blink_cnt   <= blink_cnt_d;
      opt         <= opt_d;
      start_pulse <= start_d;
    end
  end

  // Next-state logic: page transitions, menu navigation and the fade ramp.
  always_comb begin
    state_d    = state;
    sel_d      = sel;
    fade_d     = fade_level;
    fade_cnt_d = fade_cnt;
    case (state)
      ST_TITLE: begin
        if (ev_enter) begin
          state_d = ST_MENU;
          sel_d   = '0;
        end
      end
      ST_MENU: begin
        if (ev_back) begin
          state_d = ST_TITLE;
          sel_d   = '0;
        end else if (ev_enter) begin
          // Selection is committed as-is; simultaneous left/right are dropped.
          state_d    = ST_FADE;
          fade_d     = FADE_FULL;
          fade_cnt_d = '0;
        end else if (ev_right && !ev_left) begin
          sel_d = (sel == SEL_LAST) ? '0 : sel + SEL_ONE;
        end else if (ev_left && !ev_right) begin
          sel_d = (sel == '0) ? SEL_LAST : sel - SEL_ONE;
        end
      end
      ST_FADE: begin
        if (frame_tick) begin
          if (fade_cnt == FADE_LAST) begin
            fade_cnt_d = '0;
            if (fade_level == 4'd0) begin
              // Stepping below black ends the fade instead of wrapping.
              state_d = ST_RUN;
              fade_d  = FADE_FULL;
            end else begin
              fade_d = fade_level - 4'd1;
            end
          end else begin
            fade_cnt_d = fade_cnt + FADE_ONE;
          end
        end
      end
      ST_RUN: begin
        if (ev_back) begin
          state_d = ST_MENU;
        end
      end
      default: begin
        state_d = ST_TITLE;
      end
    endcase
  end

  // Output logic: highlight blink phase and the run-start pulse.
  always_comb begin
    opt_d       = opt;
    blink_cnt_d = blink_cnt;
    start_d     = (state == ST_FADE) && (state_d == ST_RUN);
    if ((state_d != state) || (sel_d != sel) ||
        (state == ST_FADE) || (state == ST_RUN)) begin
      // Any visible change restarts the blink from the "off" phase.
      opt_d       = 1'b0;
      blink_cnt_d = '0;
    end else if (frame_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_d = '0;
        opt_d       = ~opt;
      end else begin
        blink_cnt_d = blink_cnt + BLINK_ONE;
      end
    end
  end

  assign page = state;

endmodule
`default_nettype wire

// File: tb/tb_page_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_page_ctrl
//  Description : Self-checking bench for page_ctrl. Directed stimulus pushes
//                the expected output vector and the clock on which it must
//                appear; a monitor compares every output change in order.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_page_ctrl;

  logic       clk_25MHz = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic [3:0] btn;          // {back, right, left, enter}
  logic [1:0] page;
  logic [1:0] sel;
  logic       opt;
  logic [3:0] fade_level;
  logic       start_pulse;

  localparam logic [3:0] B_ENTER = 4'b0001;
  localparam logic [3:0] B_LEFT  = 4'b0010;
  localparam logic [3:0] B_RIGHT = 4'b0100;
  localparam logic [3:0] B_BACK  = 4'b1000;

  typedef struct {
    int         cyc;
    logic [9:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  page_ctrl #(
    .NUM_OPTS    (3),
    .SEL_W       (2),
    .BLINK_FRAMES(30),
    .FADE_FRAMES (4)
  ) dut (
    .clk_25MHz  (clk_25MHz),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_enter  (btn[0]),
    .btn_left   (btn[1]),
    .btn_right  (btn[2]),
    .btn_back   (btn[3]),
    .page       (page),
    .sel        (sel),
    .opt        (opt),
    .fade_level (fade_level),
    .start_pulse(start_pulse)
  );

  always #5 clk_25MHz = ~clk_25MHz;

  always @(posedge clk_25MHz) cyc <= cyc + 1;

  function automatic logic [9:0] mk(input int p, input int s, input int o,
                                    input int f, input int st);
    return {2'(p), 2'(s), 1'(o), 4'(f), 1'(st)};
  endfunction

  // Monitor: every change of the output vector must match the queue head,
  // both in value and in the clock on which it appears.
  logic [9:0] prev_v = 'x;
  always @(negedge clk_25MHz) begin
    logic [9:0] cur;
    exp_t       e;
    cur = {page, sel, opt, fade_level, start_pulse};
    if (cur !== prev_v) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got page=%0d sel=%0d opt=%0d fade=%0d start=%0d",
                 cyc, page, sel, opt, fade_level, start_pulse);
      end else begin
        e = q.pop_front();
        if (e.v !== cur || e.cyc != cyc) begin
          errors++;
          $display("FAIL outputs cyc=%0d got page=%0d sel=%0d opt=%0d fade=%0d start=%0d | want cyc=%0d page=%0d sel=%0d opt=%0d fade=%0d start=%0d",
                   cyc, page, sel, opt, fade_level, start_pulse,
                   e.cyc, e.v[9:8], e.v[7:6], e.v[5], e.v[4:1], e.v[0]);
        end
      end
    end
    prev_v = cur;
  end

  task automatic expect_at(input int c, input logic [9:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_25MHz);
      #1;
    end
  endtask

  // Pin rises now (after edge N); its effect lands on edge N+4.
  task automatic press(input logic [3:0] m, input bit exp, input logic [9:0] v);
    btn = m;
    if (exp) expect_at(cyc + 4, v);
    step(2);
    btn = 4'd0;
    step(4);
  endtask

  // One frame_tick, seen by the DUT on the next edge.
  task automatic tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(1);
  endtask

  // Full fade from 15 down to black and into RUN with selection s.
  task automatic run_fade(input int s, input bit poke);
    for (int i = 1; i <= 64; i++) begin
      if (i == 64) begin
        expect_at(cyc + 1, mk(3, s, 0, 15, 1));
        expect_at(cyc + 2, mk(3, s, 0, 15, 0));
      end else if (i % 4 == 0) begin
        expect_at(cyc + 1, mk(2, s, 0, 15 - i / 4, 0));
      end
      tick();
      if (poke && i == 10) press(4'hF, 1'b0, '0);
    end
  endtask

  initial begin
    // Reset held for five edges while inputs toggle: only the reset value.
    rst        = 1'b0;
    btn        = 4'hF;
    frame_tick = 1'b1;
    expect_at(1, mk(0, 0, 0, 15, 0));
    step(1);
    btn = 4'h0; frame_tick = 1'b0;
    step(1);
    btn = 4'hF; frame_tick = 1'b1;
    step(1);
    btn = 4'h0; frame_tick = 1'b0;
    step(2);
    rst = 1'b1;
    step(3);

    // TITLE blink: opt toggles every 30 ticks.
    for (int i = 1; i <= 90; i++) begin
      if (i % 30 == 0) expect_at(cyc + 1, mk(0, 0, (i / 30) % 2, 15, 0));
      tick();
    end
    press(B_LEFT | B_RIGHT | B_BACK, 1'b0, '0);
    press(B_ENTER, 1'b1, mk(1, 0, 0, 15, 0));

    // MENU wrap and navigation with three options.
    press(B_LEFT,  1'b1, mk(1, 2, 0, 15, 0));
    press(B_RIGHT, 1'b1, mk(1, 0, 0, 15, 0));
    press(B_RIGHT, 1'b1, mk(1, 1, 0, 15, 0));
    press(B_LEFT | B_RIGHT, 1'b0, '0);

    // A selection change restarts the blink count.
    for (int i = 0; i < 20; i++) tick();
    press(B_LEFT, 1'b1, mk(1, 0, 0, 15, 0));
    for (int i = 1; i <= 30; i++) begin
      if (i == 30) expect_at(cyc + 1, mk(1, 0, 1, 15, 0));
      tick();
    end
    press(B_RIGHT, 1'b1, mk(1, 1, 0, 15, 0));

    // Priorities: back beats enter; enter beats right.
    press(B_ENTER | B_BACK,  1'b1, mk(0, 0, 0, 15, 0));
    press(B_ENTER,           1'b1, mk(1, 0, 0, 15, 0));
    press(B_RIGHT,           1'b1, mk(1, 1, 0, 15, 0));
    press(B_ENTER | B_RIGHT, 1'b1, mk(2, 1, 0, 15, 0));

    // Fade ramp with buttons pressed mid-fade.
    run_fade(1, 1'b1);

    // RUN ignores ticks and non-back buttons; back returns to MENU.
    for (int i = 0; i < 35; i++) tick();
    press(B_ENTER | B_LEFT | B_RIGHT, 1'b0, '0);
    press(B_BACK, 1'b1, mk(1, 1, 0, 15, 0));

    // Reset in the middle of a fade at level 7.
    press(B_ENTER, 1'b1, mk(2, 1, 0, 15, 0));
    for (int i = 1; i <= 32; i++) begin
      if (i % 4 == 0) expect_at(cyc + 1, mk(2, 1, 0, 15 - i / 4, 0));
      tick();
    end
    rst = 1'b0;
    expect_at(cyc + 1, mk(0, 0, 0, 15, 0));
    step(2);
    rst = 1'b1;
    step(3);

    // Back to RUN, then RUN->MENU keeps the committed selection.
    press(B_ENTER, 1'b1, mk(1, 0, 0, 15, 0));
    press(B_RIGHT, 1'b1, mk(1, 1, 0, 15, 0));
    press(B_RIGHT, 1'b1, mk(1, 2, 0, 15, 0));
    press(B_ENTER, 1'b1, mk(2, 2, 0, 15, 0));
    run_fade(2, 1'b0);
    press(B_BACK, 1'b1, mk(1, 2, 0, 15, 0));

    step(10);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got %0d left want 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
